cve2_obi_bus_arbiter: RTL

// - Merges the core's instruction and data OBI ports into one OBI master port for single-port memories or interconnects.
// - Sits directly downstream of the core top: consumes instr_*/data_* requests and routes each response back to the port that issued it.
// - Keeps up to MaxOutstanding accepted transactions in flight. A source-ID FIFO records issue order and steers responses.

---
 rtl/cve2_pkg.sv | 15 +
 rtl/cve2_obi_id_fifo.sv | 74 +++++++
 rtl/cve2_obi_bus_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared OBI arbiter types and constants
package cve2_pkg;

    typedef enum logic {
        ObiSrcInstr = 1'b0,
        ObiSrcData  = 1'b1
    } obi_src_e;

    localparam logic [3:0] ObiInstrBe = 4'hF;

    function automatic obi_src_e obi_other_src(input obi_src_e src);
        return (src == ObiSrcInstr) ? ObiSrcData : ObiSrcInstr;
    endfunction

endpackage

// File: rtl/cve2_obi_id_fifo.sv
// rtl/cve2_obi_id_fifo.sv - source-ID FIFO recording OBI issue order
module cve2_obi_id_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  logic     pop_i,
    input  obi_src_e data_i,
    output obi_src_e data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    obi_src_e            mem_q [Depth];
    obi_src_e            mem_d [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                push_en, pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= ObiSrcInstr;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cve2_obi_bus_arbiter.sv
// rtl/cve2_obi_bus_arbiter.sv - merges instr/data OBI ports into one master port
// Optional round-robin contention policy: CVE2_OBI_ARB_ROUND_ROBIN_EN.
module cve2_obi_bus_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          DataPriority   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    logic     lock_q, lock_d;
    obi_src_e lock_src_q, lock_src_d;
    obi_src_e sel_src, head_src, contend_src;
    logic     fifo_full, fifo_empty;
    logic     grant, resp_valid, sel_data;

`ifdef CVE2_OBI_ARB_ROUND_ROBIN_EN
    obi_src_e rr_q, rr_d;

    assign contend_src = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = obi_other_src(sel_src);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= ObiSrcInstr;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign contend_src = DataPriority ? ObiSrcData : ObiSrcInstr;
`endif

    // A stalled request keeps its source until granted, regardless of new arrivals.
    always_comb begin
        sel_src = ObiSrcInstr;
        if (lock_q) begin
            sel_src = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            sel_src = contend_src;
        end else if (data_req_i) begin
            sel_src = ObiSrcData;
        end
    end

    assign bus_req_o = !fifo_full && (lock_q || instr_req_i || data_req_i);
    assign grant     = bus_req_o && bus_gnt_i;
    assign sel_data  = bus_req_o && (sel_src == ObiSrcData);

    assign instr_gnt_o = grant && (sel_src == ObiSrcInstr);
    assign data_gnt_o  = grant && (sel_src == ObiSrcData);

    assign bus_we_o    = sel_data && data_we_i;
    assign bus_be_o    = !bus_req_o ? 4'h0  : (sel_data ? data_be_i   : ObiInstrBe);
    assign bus_addr_o  = !bus_req_o ? 32'h0 : (sel_data ? data_addr_i : instr_addr_i);
    assign bus_wdata_o = sel_data ? data_wdata_i : 32'h0;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (grant) begin
            lock_d = 1'b0;
        end else if (bus_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = sel_src;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= ObiSrcInstr;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    cve2_obi_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (bus_rvalid_i),
        .data_i  (sel_src),
        .data_o  (head_src),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Responses with nothing outstanding are dropped rather than misrouted.
    assign resp_valid     = bus_rvalid_i && !fifo_empty;
    assign instr_rvalid_o = resp_valid && (head_src == ObiSrcInstr);
    assign data_rvalid_o  = resp_valid && (head_src == ObiSrcData);
    assign instr_rdata_o  = instr_rvalid_o ? bus_rdata_i : 32'h0;
    assign data_rdata_o   = data_rvalid_o  ? bus_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o && bus_err_i;
    assign data_err_o     = data_rvalid_o  && bus_err_i;

    orphan_rvalid_c: cover property (@(posedge clk_i) disable iff (!rst_ni)
        bus_rvalid_i && fifo_empty);

endmodule
